flow_tick_gen: RTL and testbench
================================

FLOW_TICK_GEN -- requirements
Module: flow_tick_gen

Interface
REQ-001 SHALL have parameter DEB_CNT, default 20, the number of consecutive stable synchronized samples needed to accept a key level change; minimum 2.
REQ-002 SHALL have parameter BASE_DIV, default 4, the step period in clk cycles at the fastest speed level; minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port key_run_n, input, 1 bit: raw run/pause push button, active-low, asynchronous to clk and bouncy.
REQ-006 SHALL have port key_speed_n, input, 1 bit: raw speed push button, active-low, asynchronous to clk and bouncy.
REQ-007 SHALL have port step_tick, output, 1 bit: one-cycle registered pulse that advances the downstream LED flow state machine.
REQ-008 SHALL have port running, output, 1 bit: 1 when step generation is enabled.
REQ-009 SHALL have port speed_lvl, output, 2 bits: current speed level; 0 is slowest, 3 is fastest.

Function
REQ-010 SHALL pass each key through a 2-flop synchronizer before any other logic uses it.
REQ-011 SHALL run one debounce FSM per key with states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT, plus a per-key stable counter.
- RELEASED: a synced 0 moves the FSM to PRESS_WAIT and clears the counter.
- PRESS_WAIT: each synced 0 increments the counter; a synced 1 returns the FSM to RELEASED; on the DEB_CNT-th consecutive 0 the FSM moves to HELD and emits a one-cycle press event.
- HELD: a synced 1 moves the FSM to RELEASE_WAIT and clears the counter.
- RELEASE_WAIT: the DEB_CNT-th consecutive 1 moves the FSM to RELEASED; any synced 0 returns it to HELD with no event.
REQ-012 SHALL emit exactly one press event per accepted press, with no auto-repeat while the key is held.
REQ-013 SHALL toggle running on each run press event, with the register updating on the edge after the event.
REQ-014 SHALL increment speed_lvl modulo 4 on each speed press event (3 wraps to 0), with the register updating on the edge after the event.
REQ-015 SHALL update running or speed_lvl exactly DEB_CNT+3 rising edges after the first edge that samples a clean, stable low key.
REQ-016 SHALL set the step period P = BASE_DIV << (3 - speed_lvl), i.e. 8x, 4x, 2x or 1x BASE_DIV for levels 0 to 3.
REQ-017 SHALL size the divider counter div_cnt to hold 8*BASE_DIV-1 without overflow.
REQ-018 SHALL, while running=1, count div_cnt 0..P-1 and wrap it to 0.
REQ-019 SHALL assert step_tick for exactly the one cycle after the edge on which div_cnt wraps from P-1 to 0.
REQ-020 SHALL hold div_cnt at 0 and step_tick at 0 while running=0.
REQ-021 SHALL clear div_cnt to 0 and suppress the tick that cycle when a speed event or run event coincides with terminal count; the next tick comes a full new period P later.
REQ-022 SHALL process run and speed events arriving in the same cycle both, independently.
REQ-023 SHALL, on the first tick after running rises, deliver it P cycles after running rises.

Reset
REQ-024 SHALL, on rst_n low, immediately and asynchronously force: running=1, speed_lvl=0, step_tick=0, div_cnt=0, synchronizers=1, both FSMs=RELEASED, and debounce counters=0.
REQ-025 SHALL treat a key held low through reset release as a fresh press, producing one event after debounce.
REQ-026 SHALL, after reset release with no keys pressed, deliver the first step_tick 8*BASE_DIV cycles after the first active edge.

Verification (DEB_CNT=4, BASE_DIV=4)
REQ-027 SHALL cover idle: release reset, keys high -> running=1, speed_lvl=0, step_tick pulses 1 cycle every 32 cycles.
REQ-028 SHALL cover speed stepping: four clean speed presses, each held 20 cycles and released 20 cycles -> speed_lvl 1,2,3,0; tick spacing 16,8,4,32 cycles.
REQ-029 SHALL cover bounce: key_speed_n low 3 cycles / high 2 cycles repeated 10 times, then high -> speed_lvl unchanged, no tick disturbance.
REQ-030 SHALL cover pause/resume: run press -> running=0 at DEB_CNT+3 edges after press, no step_tick afterwards; second press -> running=1, first tick 32 cycles later.
REQ-031 SHALL cover the collision: speed event on the terminal-count cycle -> no tick that cycle; next tick exactly the new P later.
REQ-032 SHALL cover mid-operation reset: rst_n pulsed low at speed_lvl=2 while key_speed_n is held low -> outputs return to reset values at once; after release, speed_lvl becomes 1 after DEB_CNT+3 edges, then no further change while held.

Source files
------------

// File: rtl/flow_tick_gen.sv
// Step-tick generator for an LED flow display: two debounced push buttons
// (run/pause and speed) drive a programmable divider that emits step_tick.
module flow_tick_gen #(
  parameter int DEB_CNT  = 20,
  parameter int BASE_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_run_n,
  input  logic       key_speed_n,
  output logic       step_tick,
  output logic       running,
  output logic [1:0] speed_lvl
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  localparam int DW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
  localparam int CW = $clog2(8 * BASE_DIV);

  // The sample that leaves RELEASED/HELD is the first of the stable run,
  // so the wait states accept on the (DEB_CNT-1)-th further sample.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 2);

  logic [1:0] keys_n;
  logic [1:0] press_evt;

  assign keys_n = {key_speed_n, key_run_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          evt;
    logic [DW-1:0] cnt;
    deb_state_t    state;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the
    // two-flop synchronizer into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
        state <= RELEASED;
        cnt   <= '0;
        evt   <= 1'b0;
      end else begin
        sync1 <= keys_n[k];
        sync2 <= sync1;
        evt   <= 1'b0;
        case (state)
          RELEASED: begin
            if (!sync2) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (sync2) begin
              state <= RELEASED;
            end else if (cnt == DEB_LAST) begin
              state <= HELD;
              evt   <= 1'b1;
            end else begin
              cnt <= cnt + DW'(1);
            end
          end
          HELD: begin
            if (sync2) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (!sync2) begin
              state <= HELD;
            end else if (cnt == DEB_LAST) begin
              state <= RELEASED;
            end else begin
              cnt <= cnt + DW'(1);
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end

    assign press_evt[k] = evt;
  end

  logic          run_evt;
  logic          speed_evt;
  logic [CW-1:0] div_cnt;
  logic [CW:0]   period;
  logic          terminal;

  assign run_evt   = press_evt[0];
  assign speed_evt = press_evt[1];
  assign period    = (CW + 1)'(BASE_DIV) << (2'd3 - speed_lvl);
  // ">=" rather than "==" so a speed-up mid-period wraps instead of overrunning.
  assign terminal  = ({1'b0, div_cnt} >= (period - (CW + 1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b1;
      speed_lvl <= 2'd0;
      step_tick <= 1'b0;
      div_cnt   <= '0;
    end else begin
      step_tick <= 1'b0;
      if (run_evt)   running   <= ~running;
      if (speed_evt) speed_lvl <= speed_lvl + 2'd1;

      if (!running || run_evt) begin
        div_cnt <= '0;
      end else if (terminal) begin
        div_cnt <= '0;
        // A speed change landing on terminal count restarts a full new period.
        if (!speed_evt) step_tick <= 1'b1;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_flow_tick_gen.sv
// Directed bench for flow_tick_gen at DEB_CNT=4, BASE_DIV=4: vector table for
// speed/run stepping plus hand sequences for timing corners.
module tb_flow_tick_gen;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic       clk;
  logic       rst_n;
  logic       key_run_n;
  logic       key_speed_n;
  logic       step_tick;
  logic       running;
  logic [1:0] speed_lvl;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_q[$];

  flow_tick_gen #(.DEB_CNT(DEB), .BASE_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_run_n  (key_run_n),
    .key_speed_n(key_speed_n),
    .step_tick  (step_tick),
    .running    (running),
    .speed_lvl  (speed_lvl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) if (step_tick === 1'b1) tick_q.push_back(cyc);

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         speed_key;
    logic       exp_running;
    logic [1:0] exp_speed;
    int         exp_spacing;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_ticks(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (tick_q.size() < n && t < budget) begin
      step();
      t++;
    end
    ok = (tick_q.size() >= n);
  endtask

  task automatic press(input bit speed_key, input int hold, input int rel);
    if (speed_key) key_speed_n = 1'b0; else key_run_n = 1'b0;
    repeat (hold) step();
    key_speed_n = 1'b1;
    key_run_n   = 1'b1;
    repeat (rel) step();
  endtask

  initial begin
    bit ok;
    int c0, cr, t0, base;

    vecs[0] = '{1'b1, 1'b1, 2'd1, 16};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 8};
    vecs[2] = '{1'b1, 1'b1, 2'd3, 4};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 32};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 0};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 32};

    rst_n       = 1'b0;
    key_run_n   = 1'b1;
    key_speed_n = 1'b1;
    repeat (3) step();
    check("reset_running", running, 1);
    check("reset_speed", speed_lvl, 0);
    check("reset_tick", step_tick, 0);

    // Idle: first tick 32 edges after release, then every 32 cycles.
    rst_n = 1'b1;
    base  = cyc;
    tick_q.delete();
    wait_ticks(3, 200, ok);
    check("idle_ticks_seen", ok, 1);
    if (ok) begin
      check("idle_first_tick", tick_q[0] - base, 32);
      check("idle_spacing_a", tick_q[1] - tick_q[0], 32);
      check("idle_spacing_b", tick_q[2] - tick_q[1], 32);
    end

    for (int i = 0; i < 6; i++) begin
      press(vecs[i].speed_key, 20, 20);
      check($sformatf("vec%0d_running", i), running, vecs[i].exp_running);
      check($sformatf("vec%0d_speed", i), speed_lvl, vecs[i].exp_speed);
      tick_q.delete();
      if (vecs[i].exp_spacing > 0) begin
        wait_ticks(2, 100, ok);
        check($sformatf("vec%0d_ticks_seen", i), ok, 1);
        if (ok) check($sformatf("vec%0d_spacing", i), tick_q[1] - tick_q[0], vecs[i].exp_spacing);
      end else begin
        repeat (80) step();
        check($sformatf("vec%0d_no_ticks", i), tick_q.size(), 0);
      end
    end

    // Pause: exact latency, then silence.
    c0 = cyc;
    key_run_n = 1'b0;
    wait_until(c0 + LAT - 1);
    check("pause_before_latency", running, 1);
    wait_until(c0 + LAT);
    check("pause_at_latency", running, 0);
    tick_q.delete();
    repeat (30) step();
    key_run_n = 1'b1;
    repeat (60) step();
    check("pause_no_ticks", tick_q.size(), 0);

    // Resume: first tick a full 32 cycles after running rises.
    c0 = cyc;
    key_run_n = 1'b0;
    wait_until(c0 + LAT - 1);
    check("resume_before_latency", running, 0);
    wait_until(c0 + LAT);
    check("resume_at_latency", running, 1);
    cr = cyc;
    tick_q.delete();
    repeat (13) step();
    key_run_n = 1'b1;
    wait_ticks(1, 60, ok);
    check("resume_tick_seen", ok, 1);
    if (ok) check("resume_first_tick", tick_q[0] - cr, 32);

    // Bounce: 3-low/2-high bursts never reach the stable count.
    tick_q.delete();
    for (int i = 0; i < 10; i++) begin
      key_speed_n = 1'b0;
      repeat (3) step();
      key_speed_n = 1'b1;
      repeat (2) step();
    end
    repeat (40) step();
    check("bounce_speed", speed_lvl, 0);
    check("bounce_ticks_seen", tick_q.size() >= 2, 1);
    for (int i = 1; i < tick_q.size(); i++)
      check("bounce_spacing", tick_q[i] - tick_q[i-1], 32);

    // Collision: speed event lands exactly on terminal count.
    tick_q.delete();
    wait_ticks(1, 60, ok);
    check("collide_sync_tick", ok, 1);
    if (ok) begin
      t0 = tick_q[0];
      wait_until(t0 + 32 - LAT);
      key_speed_n = 1'b0;
      tick_q.delete();
      wait_until(t0 + 32);
      check("collide_tick_suppressed", step_tick, 0);
      check("collide_speed", speed_lvl, 1);
      wait_ticks(1, 40, ok);
      check("collide_next_seen", ok, 1);
      if (ok) check("collide_next_tick", tick_q[0] - t0, 48);
      key_speed_n = 1'b1;
      repeat (20) step();
    end

    press(1'b1, 20, 20);
    check("pre_reset_speed", speed_lvl, 2);

    // Mid-operation reset with the speed key held through release.
    key_speed_n = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_running", running, 1);
    check("midreset_speed", speed_lvl, 0);
    check("midreset_tick", step_tick, 0);
    repeat (2) step();
    rst_n = 1'b1;
    base  = cyc;
    wait_until(base + LAT - 1);
    check("held_reset_before_latency", speed_lvl, 0);
    wait_until(base + LAT);
    check("held_reset_at_latency", speed_lvl, 1);
    repeat (60) step();
    check("held_no_repeat", speed_lvl, 1);
    key_speed_n = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
